// File: rtl/bidir_bus_ctrl_if.sv
// bidir_bus_ctrl_if: client and buffer-side signal bundle of the bidirectional bus controller
// Controller view: i_wr_valid/i_wr_data/o_wr_ready write handshake, i_rd_req/o_rd_valid/o_rd_data
// read path, o_dir_en buffer direction, o_line_out/i_line_in line data, o_busy activity flag.
// master = client/buffer side, slave = controller.
interface bidir_bus_ctrl_if #(parameter int WIDTH = 8);
  logic             i_wr_valid;
  logic [WIDTH-1:0] i_wr_data;
  logic             o_wr_ready;
  logic             i_rd_req;
  logic             o_rd_valid;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_dir_en;
  logic [WIDTH-1:0] o_line_out;
  logic [WIDTH-1:0] i_line_in;
  logic             o_busy;
  modport master (
    output i_wr_valid, i_wr_data, i_rd_req, i_line_in,
    input  o_wr_ready, o_rd_valid, o_rd_data, o_dir_en, o_line_out, o_busy
  );
  modport slave (
    input  i_wr_valid, i_wr_data, i_rd_req, i_line_in,
    output o_wr_ready, o_rd_valid, o_rd_data, o_dir_en, o_line_out, o_busy
  );
endinterface

// File: rtl/bidir_bus_ctrl.sv
// bidir_bus_ctrl: half-duplex line direction controller with turnaround insertion and burst fairness
// Ports: clk rising-edge clock, rst_n async active-low reset, bus (slave modport) carrying the
// client write/read handshakes, buffer direction enable, outbound and inbound line data, busy.
module bidir_bus_ctrl #(
  parameter int WIDTH     = 8,
  parameter int TURN_CYC  = 2,
  parameter int MAX_BURST = 16
) (
  input logic             clk,
  input logic             rst_n,
  bidir_bus_ctrl_if.slave bus
);
  localparam int TW = $clog2(TURN_CYC + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, TURN, TX, RX} state_t;
  state_t           r_state, r_target;
  logic             r_dir_en, r_rd_valid, r_rd_prio;
  logic [WIDTH-1:0] r_line_out, r_rd_data;
  logic [TW-1:0]    r_turn;
  logic [BW-1:0]    r_burst;
  logic [BW-1:0]    w_burst_nxt;
  logic             w_wr_go;
  assign w_burst_nxt = (r_burst == BW'(MAX_BURST)) ? r_burst : r_burst + 1'b1;
  // a burst cut short by the limit hands the next IDLE decision to the waiting reader
  assign w_wr_go = bus.i_wr_valid && !(r_rd_prio && bus.i_rd_req);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_target   <= IDLE;
      r_dir_en   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_prio  <= 1'b0;
      r_line_out <= '0;
      r_rd_data  <= '0;
      r_turn     <= '0;
      r_burst    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rd_valid <= 1'b0;
          r_rd_prio  <= 1'b0;
          r_turn     <= '0;
          r_burst    <= '0;
          if (w_wr_go) begin
            r_state  <= r_dir_en ? TX : TURN;
            r_target <= TX;
            r_dir_en <= 1'b1;
          end else if (bus.i_rd_req) begin
            r_state  <= r_dir_en ? TURN : RX;
            r_target <= RX;
            r_dir_en <= 1'b0;
          end
        end
        TURN: begin
          r_turn <= r_turn + 1'b1;
          if (r_turn == TW'(TURN_CYC - 1)) begin
            r_state <= r_target;
            r_turn  <= '0;
          end
        end
        TX: begin
          if (bus.i_wr_valid) begin
            r_line_out <= bus.i_wr_data;
            r_burst    <= w_burst_nxt;
            if (bus.i_rd_req && w_burst_nxt == BW'(MAX_BURST)) begin
              r_state   <= IDLE;
              r_rd_prio <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RX: begin
          r_rd_valid <= bus.i_rd_req;
          if (bus.i_rd_req) r_rd_data <= bus.i_line_in;
          else r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.o_wr_ready = r_state == TX;
  assign bus.o_busy     = r_state != IDLE;
  assign bus.o_dir_en   = r_dir_en;
  assign bus.o_rd_valid = r_rd_valid;
  assign bus.o_rd_data  = r_rd_data;
  assign bus.o_line_out = r_line_out;
endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// tb_bidir_bus_ctrl: scoreboard bench for bidir_bus_ctrl with a transaction-level reference model
module tb_bidir_bus_ctrl;
  localparam int TURN = 2;
  localparam int MAXB = 4;
  logic clk, rst_n;
  bidir_bus_ctrl_if #(.WIDTH(8)) bus ();
  bidir_bus_ctrl #(.WIDTH(8), .TURN_CYC(TURN), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct packed {
    logic       rdy, busy, dir, rdv;
    logic [7:0] line, rdd;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rd[$];
  int errors = 0;
  int checks = 0;
  logic       m_dir, m_tx, m_rx, m_rdv, m_prio, m_goal_tx;
  int         m_wait, m_words;
  logic [7:0] m_line, m_rdd;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask
  task automatic model_reset();
    {m_dir, m_tx, m_rx, m_rdv, m_prio, m_goal_tx} = '0;
    m_wait = 0; m_words = 0; m_line = 0; m_rdd = 0;
    exp_q.delete(); exp_tx.delete(); exp_rd.delete();
  endtask
  // expected outputs for this cycle are queued, then the model advances to the next edge
  task automatic model_step(input logic wv, input logic [7:0] wd, input logic rr, input logic [7:0] li);
    exp_t e;
    logic go_w;
    e.rdy = m_tx; e.busy = m_tx || m_rx || m_wait > 0; e.dir = m_dir;
    e.rdv = m_rdv; e.line = m_line; e.rdd = m_rdd;
    exp_q.push_back(e);
    if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_tx = m_goal_tx; m_rx = !m_goal_tx; m_words = 0;
      end
    end else if (m_tx) begin
      if (!wv) m_tx = 0;
      else begin
        m_line = wd; exp_tx.push_back(wd); m_words++;
        if (rr && m_words >= MAXB) begin m_tx = 0; m_prio = 1; end
      end
    end else if (m_rx) begin
      m_rdv = rr;
      if (rr) begin m_rdd = li; exp_rd.push_back(li); end
      else m_rx = 0;
    end else begin
      go_w = wv && !(m_prio && rr);
      m_prio = 0;
      if (go_w) begin
        if (m_dir) begin m_tx = 1; m_words = 0; end
        else begin m_dir = 1; m_wait = TURN; m_goal_tx = 1; end
      end else if (rr) begin
        if (!m_dir) m_rx = 1;
        else begin m_dir = 0; m_wait = TURN; m_goal_tx = 0; end
      end
    end
  endtask
  task automatic step(input logic wv, input logic [7:0] wd, input logic rr, input logic [7:0] li);
    @(negedge clk);
    bus.i_wr_valid = wv; bus.i_wr_data = wd; bus.i_rd_req = rr; bus.i_line_in = li;
    model_step(wv, wd, rr, li);
  endtask
  logic hs_pend = 1'b0;
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] d;
    #2;
    if (!rst_n) hs_pend = 1'b0;
    else begin
      if (hs_pend) begin
        if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
        else begin d = exp_tx.pop_front(); chk("tx_word", bus.o_line_out, d); end
      end
      hs_pend = bus.i_wr_valid && bus.o_wr_ready;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_ready", bus.o_wr_ready, e.rdy);
        chk("busy", bus.o_busy, e.busy);
        chk("dir_en", bus.o_dir_en, e.dir);
        chk("rd_valid", bus.o_rd_valid, e.rdv);
        chk("line_out", bus.o_line_out, e.line);
        chk("rd_data", bus.o_rd_data, e.rdd);
      end
      if (bus.o_rd_valid) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else begin d = exp_rd.pop_front(); chk("rd_word", bus.o_rd_data, d); end
      end
    end
  end
  initial begin
    logic wv_r, rr_r;
    int   n;
    rst_n = 1'b0;
    bus.i_wr_valid = 0; bus.i_wr_data = 0; bus.i_rd_req = 0; bus.i_line_in = 0;
    model_reset();
    #12;
    chk("rst_dir_en", bus.o_dir_en, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_line_out", bus.o_line_out, 0);
    @(negedge clk); #3 rst_n = 1'b1;
    step(1, 8'hA5, 0, 0);
    step(1, 8'hA5, 0, 0); #3;
    chk("first_dir_en", bus.o_dir_en, 1);
    chk("first_ready_n1", bus.o_wr_ready, 0);
    step(1, 8'hA5, 0, 0); #3 chk("first_ready_n2", bus.o_wr_ready, 0);
    step(1, 8'hA5, 0, 0); #3 chk("first_ready_n3", bus.o_wr_ready, 1);
    step(0, 0, 0, 0); #3 chk("first_line_out", bus.o_line_out, 8'hA5);
    step(1, 8'h01, 0, 0);
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1, 8'(i), 0, 0); #3;
      if (bus.i_wr_valid && bus.o_wr_ready) n++;
    end
    chk("burst_handshakes", n, 6);
    step(0, 0, 0, 0); #3 chk("burst_last", bus.o_line_out, 8'h06);
    step(1, 8'h10, 1, 8'h3C);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 8'h10 + 8'(i), 1, 8'h3C); #3;
      if (bus.i_wr_valid && bus.o_wr_ready) n++;
    end
    chk("fair_burst_len", n, MAXB);
    step(0, 0, 1, 8'h3C); #3 chk("read_data", bus.o_rd_data, 8'h3C);
    step(0, 0, 0, 0); #3 chk("read_valid_hi", bus.o_rd_valid, 1);
    step(0, 0, 0, 0); #3 chk("read_valid_lo", bus.o_rd_valid, 0);
    chk("read_idle", bus.o_busy, 0);
    step(1, 8'h20, 1, 8'h55);
    step(1, 8'h20, 1, 8'h55);
    step(1, 8'h20, 1, 8'h55);
    step(1, 8'h20, 1, 8'h55); #3;
    chk("contend_ready", bus.o_wr_ready, 1);
    chk("contend_dir", bus.o_dir_en, 1);
    step(1, 8'h21, 1, 8'h55);
    @(posedge clk); #3;
    rst_n = 1'b0;
    bus.i_wr_valid = 0; bus.i_rd_req = 0;
    #1;
    chk("arst_dir_en", bus.o_dir_en, 0);
    chk("arst_rd_valid", bus.o_rd_valid, 0);
    chk("arst_wr_ready", bus.o_wr_ready, 0);
    chk("arst_line_out", bus.o_line_out, 0);
    chk("arst_busy", bus.o_busy, 0);
    model_reset();
    @(negedge clk); #3 rst_n = 1'b1;
    #1 chk("post_rst_busy", bus.o_busy, 0);
    wv_r = 0; rr_r = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) wv_r = ~wv_r;
      if ($urandom_range(0, 7) == 0) rr_r = ~rr_r;
      step(wv_r, 8'($urandom), rr_r, 8'($urandom));
    end
    for (int k = 0; k < 12; k++) step(0, 0, 0, 0);
    @(negedge clk); #3;
    chk("tx_left", exp_tx.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
